// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage.
// Holds the ISA field positions used by downstream decode/stall logic,
// the bubble instruction word, the fetch FSM state encoding and the
// default widths shared by the interface and the top module.
package fetch_stage_pkg;

  // ISA field positions (msb/lsb) as seen by decode and stall control.
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 27;
  localparam int RD_MSB     = 26;
  localparam int RD_LSB     = 22;
  localparam int RS_MSB     = 21;
  localparam int RS_LSB     = 17;
  localparam int RT_MSB     = 16;
  localparam int RT_LSB     = 12;

  // Instruction word injected into squashed / empty slots.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Default widths.
  localparam int IMEM_ADDR_W   = 12;
  localparam int PERF_CNT_W    = 32;

  // EMPTY: q_imem does not hold a usable instruction.
  // FULL : q_imem holds the instruction at if_pc.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Bus bundle between the fetch stage and its environment.
// Carries stall/redirect control from the hazard and execute logic, the
// instruction ROM port (address out, data in), the F/D latch outputs and
// the performance counters.
//   master : fetch stage side (drives address, F/D latch, counters)
//   slave  : environment side (drives stall, redirect, target, ROM data)
interface fetch_stage_if
  import fetch_stage_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int CNT_W  = PERF_CNT_W
);
  logic              stall;
  logic              redirect;
  logic [31:0]       redirect_target;
  logic [ADDR_W-1:0] address_imem;
  logic [31:0]       q_imem;
  logic [31:0]       fd_ir;
  logic [31:0]       fd_pc;
  logic              fd_valid;
  logic [CNT_W-1:0]  cnt_fetch;
  logic [CNT_W-1:0]  cnt_stall;
  logic [CNT_W-1:0]  cnt_flush;

  modport master (
    input  stall, redirect, redirect_target, q_imem,
    output address_imem, fd_ir, fd_pc, fd_valid,
    output cnt_fetch, cnt_stall, cnt_flush
  );

  modport slave (
    output stall, redirect, redirect_target, q_imem,
    input  address_imem, fd_ir, fd_pc, fd_valid,
    input  cnt_fetch, cnt_stall, cnt_flush
  );
endinterface

// File: rtl/fetch_perf_counters.sv
// Three free-running event counters for the fetch stage.
// Ports:
//   clock, reset                      rising-edge clock, sync active-high reset
//   en_fetch, en_stall, en_flush      count enables (one event per cycle)
//   cnt_fetch, cnt_stall, cnt_flush   counter values, wrap modulo 2^CNT_W
module fetch_perf_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en_fetch,
  input  logic             en_stall,
  input  logic             en_flush,
  output logic [CNT_W-1:0] cnt_fetch,
  output logic [CNT_W-1:0] cnt_stall,
  output logic [CNT_W-1:0] cnt_flush
);
  logic [2:0] en;
  assign en = {en_flush, en_stall, en_fetch};

  for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt_reg;
    always_ff @(posedge clock) begin
      if (reset) begin
        cnt_reg <= '0;
      end else if (en[gi]) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  assign cnt_fetch = g_cnt[0].cnt_reg;
  assign cnt_stall = g_cnt[1].cnt_reg;
  assign cnt_flush = g_cnt[2].cnt_reg;
endmodule

// File: rtl/fetch_stage.sv
// Fetch stage and F/D pipeline latch.
// Owns the fetch PC, drives the synchronous instruction ROM (one cycle read
// latency) and loads the F/D latch. Honours load-use stall and the X-stage
// redirect; squashed slots carry NOP with fd_valid=0.
// Ports:
//   clock, reset  rising-edge clock, synchronous active-high reset
//   bus           fetch_stage_if.master: stall, redirect, redirect_target,
//                 address_imem, q_imem, fd_ir, fd_pc, fd_valid, counters
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int          ADDR_W = IMEM_ADDR_W,
  parameter logic [31:0] NOP    = NOP_INSTR,
  parameter int          CNT_W  = PERF_CNT_W
) (
  input logic            clock,
  input logic            reset,
  fetch_stage_if.master  bus
);
  fetch_state_t state_reg, state_next;
  logic [31:0]  pc_reg, pc_next;        // next address to fetch
  logic [31:0]  if_pc_reg, if_pc_next;  // address whose data is on q_imem
  logic [31:0]  fd_ir_reg, fd_ir_next;
  logic [31:0]  fd_pc_reg, fd_pc_next;
  logic         fd_valid_reg, fd_valid_next;
  logic         fetch_event;
  logic         hold;

  assign hold = bus.stall && !bus.redirect;

  // During a stall the ROM re-reads if_pc so q_imem stays valid for any
  // stall length. On redirect the target is presented straight away.
  always_comb begin
    if (bus.redirect) begin
      bus.address_imem = bus.redirect_target[ADDR_W-1:0];
    end else if (bus.stall) begin
      bus.address_imem = if_pc_reg[ADDR_W-1:0];
    end else begin
      bus.address_imem = pc_reg[ADDR_W-1:0];
    end
  end

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    if_pc_next    = if_pc_reg;
    fd_ir_next    = fd_ir_reg;
    fd_pc_next    = fd_pc_reg;
    fd_valid_next = fd_valid_reg;
    fetch_event   = 1'b0;
    if (bus.redirect) begin
      // Restart the fetch stream at the target exactly as after reset:
      // one more bubble (F slot) follows this one (D slot), then the
      // target instruction arrives with fd_pc = target + 1.
      fd_ir_next    = NOP;
      fd_valid_next = 1'b0;
      fd_pc_next    = '0;
      pc_next       = bus.redirect_target;
      if_pc_next    = bus.redirect_target;
      state_next    = EMPTY;
    end else if (!bus.stall) begin
      if (state_reg == FULL) begin
        fd_ir_next    = bus.q_imem;
        fd_valid_next = 1'b1;
        fd_pc_next    = if_pc_reg + 32'd1;
        fetch_event   = 1'b1;
      end else begin
        fd_ir_next    = NOP;
        fd_valid_next = 1'b0;
        fd_pc_next    = '0;
      end
      if_pc_next = pc_reg;
      pc_next    = pc_reg + 32'd1;
      state_next = FULL;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= EMPTY;
      pc_reg       <= '0;
      if_pc_reg    <= '0;
      fd_ir_reg    <= NOP;
      fd_pc_reg    <= '0;
      fd_valid_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      if_pc_reg    <= if_pc_next;
      fd_ir_reg    <= fd_ir_next;
      fd_pc_reg    <= fd_pc_next;
      fd_valid_reg <= fd_valid_next;
    end
  end

  assign bus.fd_ir    = fd_ir_reg;
  assign bus.fd_pc    = fd_pc_reg;
  assign bus.fd_valid = fd_valid_reg;

  fetch_perf_counters #(.CNT_W(CNT_W)) u_perf (
    .clock     (clock),
    .reset     (reset),
    .en_fetch  (fetch_event),
    .en_stall  (hold),
    .en_flush  (bus.redirect),
    .cnt_fetch (bus.cnt_fetch),
    .cnt_stall (bus.cnt_stall),
    .cnt_flush (bus.cnt_flush)
  );
endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios, a stream-level reference
// model checked every cycle, and literal expectations at key points.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  fetch_stage_if #(.ADDR_W(12), .CNT_W(32)) bus ();

  fetch_stage #(.ADDR_W(12), .NOP(NOP_INSTR), .CNT_W(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  // Synchronous ROM, word i = 0x1000_0000 + i.
  logic [31:0] rom [4096];
  initial for (int i = 0; i < 4096; i++) rom[i] = 32'h1000_0000 + i;
  always @(posedge clock) bus.q_imem <= rom[bus.address_imem];

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'h1000_0000 + (a & 32'h0000_0FFF);
  endfunction

  // Stream model: after reset or a redirect to base, successive advances
  // deliver bubble, ROM[base], ROM[base+1], ... ; stalls freeze the stream.
  logic [31:0] m_base;
  int          m_k;
  logic [31:0] m_ir, m_pc;
  logic        m_v;
  logic [31:0] m_cf, m_cs, m_cfl;
  bit          m_live = 0;

  always @(posedge clock) begin
    if (reset) begin
      m_base = 0; m_k = 0; m_ir = NOP_INSTR; m_pc = 0; m_v = 0;
      m_cf = 0; m_cs = 0; m_cfl = 0; m_live = 1;
    end else if (bus.redirect) begin
      m_base = bus.redirect_target; m_k = 0;
      m_ir = NOP_INSTR; m_pc = 0; m_v = 0; m_cfl++;
    end else if (bus.stall) begin
      m_cs++;
    end else begin
      m_k++;
      if (m_k == 1) begin
        m_ir = NOP_INSTR; m_pc = 0; m_v = 0;
      end else begin
        m_ir = rom_word(m_base + 32'(m_k) - 32'd2);
        m_pc = m_base + 32'(m_k) - 32'd1;
        m_v  = 1; m_cf++;
      end
    end
  end

  function automatic logic [11:0] model_addr();
    logic [31:0] a;
    if (bus.redirect) a = bus.redirect_target;
    else if (bus.stall) a = (m_k == 0) ? m_base : m_base + 32'(m_k) - 32'd1;
    else a = m_base + 32'(m_k);
    return a[11:0];
  endfunction

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (m_live) begin
      check("fd_ir", bus.fd_ir, m_ir);
      check("fd_pc", bus.fd_pc, m_pc);
      check("fd_valid", bus.fd_valid, m_v);
      check("address_imem", bus.address_imem, model_addr());
      check("cnt_fetch", bus.cnt_fetch, m_cf);
      check("cnt_stall", bus.cnt_stall, m_cs);
      check("cnt_flush", bus.cnt_flush, m_cfl);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    bus.stall = 0; bus.redirect = 0; bus.redirect_target = 0;

    // 1. Reset 3 cycles, then stream from address 0.
    step(3);
    check("rst_fd_valid", bus.fd_valid, 0);
    check("rst_fd_ir", bus.fd_ir, NOP_INSTR);
    check("rst_cnt_fetch", bus.cnt_fetch, 0);
    reset = 0;
    step(1);
    check("s1_first_valid", bus.fd_valid, 0);
    for (int i = 0; i < 4; i++) begin
      step(1);
      check("s1_fd_ir", bus.fd_ir, 32'h1000_0000 + i);
      check("s1_fd_pc", bus.fd_pc, i + 1);
    end
    check("s1_cnt_fetch", bus.cnt_fetch, 4);
    check("s1_model_cnt", m_cf, 4);

    // 2. Stall 3 cycles with ROM[3] in F/D; ROM re-reads address 4.
    bus.stall = 1;
    #1 check("s2_addr", bus.address_imem, 12'd4);
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("s2_hold_ir", bus.fd_ir, 32'h1000_0003);
      check("s2_hold_pc", bus.fd_pc, 4);
      check("s2_hold_addr", bus.address_imem, 12'd4);
    end
    bus.stall = 0;
    step(1);
    check("s2_release_ir", bus.fd_ir, 32'h1000_0004);
    check("s2_cnt_stall", bus.cnt_stall, 3);

    // 3. Redirect to 40 while ROM[5] is in F/D.
    step(1);
    check("s3_pre_ir", bus.fd_ir, 32'h1000_0005);
    bus.redirect = 1; bus.redirect_target = 32'd40;
    step(1);
    bus.redirect = 0;
    check("s3_bubble1", {bus.fd_valid, bus.fd_ir}, {1'b0, NOP_INSTR});
    step(1);
    check("s3_bubble2", {bus.fd_valid, bus.fd_ir}, {1'b0, NOP_INSTR});
    step(1);
    check("s3_target_ir", bus.fd_ir, 32'h1000_0028);
    check("s3_target_pc", bus.fd_pc, 41);
    check("s3_model_pc", m_pc, 41);
    check("s3_cnt_flush", bus.cnt_flush, 1);

    // 4. Redirect and stall together: redirect wins, no stall counted.
    bus.redirect = 1; bus.stall = 1; bus.redirect_target = 32'd100;
    step(1);
    bus.redirect = 0; bus.stall = 0;
    check("s4_bubble1", bus.fd_valid, 0);
    step(1);
    check("s4_bubble2", bus.fd_valid, 0);
    step(1);
    check("s4_target_ir", bus.fd_ir, 32'h1000_0064);
    check("s4_target_pc", bus.fd_pc, 101);
    check("s4_cnt_stall", bus.cnt_stall, 3);
    check("s4_cnt_flush", bus.cnt_flush, 2);

    // 5. Reset during a stall, then during a redirect.
    bus.stall = 1;
    step(1);
    reset = 1;
    step(1);
    check("s5_rst_valid", bus.fd_valid, 0);
    check("s5_rst_pc", bus.fd_pc, 0);
    check("s5_rst_cnt_stall", bus.cnt_stall, 0);
    bus.stall = 0; bus.redirect = 1; bus.redirect_target = 32'd77;
    step(1);
    check("s5_rst2_ir", bus.fd_ir, NOP_INSTR);
    check("s5_rst2_cnt_flush", bus.cnt_flush, 0);
    reset = 0; bus.redirect = 0;
    step(1);
    check("s5_first_valid", bus.fd_valid, 0);
    step(1);
    check("s5_ir0", bus.fd_ir, 32'h1000_0000);
    check("s5_pc0", bus.fd_pc, 1);

    // 6. Redirect to 0xFFFF_FFFF: wrap of PC and alias of the ROM address.
    bus.redirect = 1; bus.redirect_target = 32'hFFFF_FFFF;
    #1 check("s6_addr_redirect", bus.address_imem, 12'hFFF);
    step(1);
    bus.redirect = 0;
    #1 check("s6_addr_target", bus.address_imem, 12'hFFF);
    step(1);
    check("s6_addr_wrap", bus.address_imem, 12'h000);
    step(1);
    check("s6_fd_pc_wrap", bus.fd_pc, 0);
    check("s6_fd_ir", bus.fd_ir, 32'h1000_0FFF);
    step(1);
    check("s6_fd_pc_next", bus.fd_pc, 1);
    check("s6_fd_ir_next", bus.fd_ir, 32'h1000_0000);

    // Mixed tail: alternate stalls and advances.
    for (int i = 0; i < 8; i++) begin
      bus.stall = i[0];
      step(1);
    end
    bus.stall = 0;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
